cla16_sub_pipe: RTL and testbench

- Two-stage pipelined 16-bit subtractor computing D = A - B - Bin. Inverse companion to the team's combinational 16-bit carry-lookahead adder.
- Built from 4-bit generate/propagate lookahead groups.
- Stage 1 resolves the low half and its carry; stage 2 resolves the high half and flags.
- Valid/ready streaming interfaces on both sides, so it sits in the datapath between a register-file read port and the writeback mux.

---
 rtl/cla16_sub_pipe_if.sv | 28 ++
 rtl/cla16_sub_pipe.sv | 151 +++++++++++++++
 tb/tb_cla16_sub_pipe.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cla16_sub_pipe_if.sv
// Operand/result stream bundle for the pipelined lookahead subtractor.
// Latency: none (wires only).
// Backpressure: carries in_ready/out_ready; slave = subtractor, master = driver side.
interface cla16_sub_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, d, bout, ovf, zero
   );

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, d, bout, ovf, zero
   );
endinterface

// File: rtl/cla16_sub_pipe.sv
// Two-stage pipelined subtractor d = a - b - bin from GROUP-bit lookahead groups; optional signed saturation via CLA16_SUB_SAT_EN.
// Latency: 2 cycles (beat presented in cycle N appears on out_valid in cycle N+2); one result per cycle at full rate.
// Backpressure: s1 stalls behind a held s2; in_ready drops only when both stages are full and out_ready is low.
module cla16_sub_pipe #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   cla16_sub_pipe_if.slave    bus
);

   localparam int H  = WIDTH / 2;
   localparam int NG = H / GROUP;

   if (((WIDTH % 8) != 0) || ((H % GROUP) != 0)) begin : g_bad_param
      $error("cla16_sub_pipe: WIDTH must be a multiple of 8 and GROUP must divide WIDTH/2");
   end

   // Half-width adder: group generate/propagate feed the inter-group carries,
   // bit sums are then formed from each group's incoming carry.
   function automatic logic [H:0] cla_half(input logic [H-1:0] x,
                                           input logic [H-1:0] y,
                                           input logic         cin);
      logic [H-1:0] g;
      logic [H-1:0] p;
      logic [H-1:0] s;
      logic [NG:0]  gc;
      logic         gg;
      logic         gp;
      logic         c;
      g     = x & y;
      p     = x ^ y;
      s     = '0;
      gc    = '0;
      gc[0] = cin;
      for (int k = 0; k < NG; k++) begin
         gg = 1'b0;
         gp = 1'b1;
         for (int i = 0; i < GROUP; i++) begin
            gg = g[k*GROUP+i] | (p[k*GROUP+i] & gg);
            gp = gp & p[k*GROUP+i];
         end
         gc[k+1] = gg | (gp & gc[k]);
      end
      for (int k = 0; k < NG; k++) begin
         c = gc[k];
         for (int i = 0; i < GROUP; i++) begin
            s[k*GROUP+i] = p[k*GROUP+i] ^ c;
            c            = g[k*GROUP+i] | (p[k*GROUP+i] & c);
         end
      end
      return {gc[NG], s};
   endfunction

   // Stage 1 state
   logic             s1_valid;
   logic [H-1:0]     s1_lo;
   logic             s1_c;
   logic [H-1:0]     s1_ahi;
   logic [H-1:0]     s1_nbhi;
   logic             s1_asgn;
   logic             s1_bsgn;

   // Stage 2 state
   logic             s2_valid;
   logic [WIDTH-1:0] s2_d;
   logic             s2_bout;
   logic             s2_ovf;
   logic             s2_zero;

   logic             s2_free;
   logic             s1_adv;
   logic             accept;
   logic [H:0]       lo_sum;
   logic [H:0]       hi_sum;
   logic [WIDTH-1:0] d_wrap;
   logic [WIDTH-1:0] d_fin;
   logic             ovf_c;

   assign s2_free      = !s2_valid || bus.out_ready;
   assign s1_adv       = s1_valid && s2_free;
   assign bus.in_ready = !s1_valid || s2_free;
   assign accept       = bus.in_valid && bus.in_ready;

   // Low half uses ~bin as carry-in; high half continues from the registered carry.
   assign lo_sum = cla_half(bus.a[H-1:0], ~bus.b[H-1:0], ~bus.bin);
   assign hi_sum = cla_half(s1_ahi, s1_nbhi, s1_c);
   assign d_wrap = {hi_sum[H-1:0], s1_lo};
   assign ovf_c  = (s1_asgn != s1_bsgn) && (d_wrap[WIDTH-1] != s1_asgn);

`ifdef CLA16_SUB_SAT_EN
   // Clamp to the most positive/negative value in the direction of the minuend's sign.
   assign d_fin = ovf_c ? {s1_asgn, {(WIDTH-1){~s1_asgn}}} : d_wrap;
`else
   assign d_fin = d_wrap;
`endif

   // Stage 1: capture low-half result and the operands still needed for the high half.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_c     <= 1'b0;
         s1_ahi   <= '0;
         s1_nbhi  <= '0;
         s1_asgn  <= 1'b0;
         s1_bsgn  <= 1'b0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_lo    <= lo_sum[H-1:0];
            s1_c     <= lo_sum[H];
            s1_ahi   <= bus.a[WIDTH-1:H];
            s1_nbhi  <= ~bus.b[WIDTH-1:H];
            s1_asgn  <= bus.a[WIDTH-1];
            s1_bsgn  <= bus.b[WIDTH-1];
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2: finish the high half and register result plus flags; hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_d     <= '0;
         s2_bout  <= 1'b0;
         s2_ovf   <= 1'b0;
         s2_zero  <= 1'b0;
      end else begin
         if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_d     <= d_fin;
            s2_bout  <= ~hi_sum[H];
            s2_ovf   <= ovf_c;
            s2_zero  <= (d_fin == '0);
         end else if (bus.out_ready) begin
            s2_valid <= 1'b0;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.d         = s2_d;
   assign bus.bout      = s2_bout;
   assign bus.ovf       = s2_ovf;
   assign bus.zero      = s2_zero;

endmodule

// File: tb/tb_cla16_sub_pipe.sv
// Randomised and directed bench for cla16_sub_pipe against an arithmetic reference model.
// Latency: expects results two cycles after acceptance, later only under backpressure.
// Backpressure: drives random out_ready and checks in_ready/out_valid against beat occupancy.
module tb_cla16_sub_pipe;

   logic clk;
   logic rst_n;

   cla16_sub_pipe_if #(.WIDTH(16)) sif ();

   cla16_sub_pipe #(.WIDTH(16), .GROUP(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        bout;
      logic        ovf;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference: plain integer subtraction, unsigned for borrow, signed for overflow.
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                  input logic bi, input int acc);
      exp_t        e;
      int          ud;
      int          sd;
      logic [31:0] u32;
      ud     = int'(av) - int'(bv) - int'(bi);
      sd     = int'($signed(av)) - int'($signed(bv)) - int'(bi);
      u32    = ud;
      e.d    = u32[15:0];
      e.bout = (ud < 0);
      e.ovf  = (sd > 32767) || (sd < -32768);
`ifdef CLA16_SUB_SAT_EN
      if (e.ovf) e.d = (sd < 0) ? 16'h8000 : 16'h7FFF;
`endif
      e.zero = (e.d == 16'h0000);
      e.acc  = acc;
      return e;
   endfunction

   // One cycle: drive after the edge, then at the falling edge check outputs and
   // record the handshakes that the next rising edge will perform.
   task automatic step(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic bi, input logic ordy, output logic acc);
      logic ov_exp;
      logic ir_exp;
      @(posedge clk);
      #1;
      sif.in_valid  = v;
      sif.a         = av;
      sif.b         = bv;
      sif.bin       = bi;
      sif.out_ready = ordy;
      @(negedge clk);
      cyc++;
      ov_exp = (q.size() > 0) && (cyc >= q[0].acc + 2);
      ir_exp = !((q.size() == 2) && !ordy);
      chk("out_valid", {31'd0, sif.out_valid}, {31'd0, ov_exp});
      chk("in_ready", {31'd0, sif.in_ready}, {31'd0, ir_exp});
      if (sif.out_valid && q.size() > 0) begin
         chk("d", {16'd0, sif.d}, {16'd0, q[0].d});
         chk("bout", {31'd0, sif.bout}, {31'd0, q[0].bout});
         chk("ovf", {31'd0, sif.ovf}, {31'd0, q[0].ovf});
         chk("zero", {31'd0, sif.zero}, {31'd0, q[0].zero});
         if (ordy) void'(q.pop_front());
      end
      acc = v && sif.in_ready;
      if (acc) q.push_back(model(av, bv, bi, cyc));
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, acc);
      chk(tag, q.size(), 0);
   endtask

   task automatic send1(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      logic acc;
      step(1'b1, av, bv, bi, 1'b1, acc);
      chk("send_accept", {31'd0, acc}, 32'd1);
      drain("send_drain");
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, {31'd0, sif.out_valid}, 32'd0);
      chk({tag, "_d"}, {16'd0, sif.d}, 32'd0);
      chk({tag, "_bout"}, {31'd0, sif.bout}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, sif.ovf}, 32'd0);
      chk({tag, "_zero"}, {31'd0, sif.zero}, 32'd0);
      chk({tag, "_in_ready"}, {31'd0, sif.in_ready}, 32'd1);
   endtask

   logic [15:0] bp_a [5];
   logic [15:0] bp_b [5];

   initial begin
      logic acc;
      int   idx;
      int   n;
      sif.in_valid  = 1'b0;
      sif.a         = '0;
      sif.b         = '0;
      sif.bin       = 1'b0;
      sif.out_ready = 1'b0;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;
      #3 check_reset_outputs("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases, each drained before the next.
      send1(16'h0005, 16'h0003, 1'b0);
      send1(16'h0000, 16'h0001, 1'b0);
      send1(16'h0100, 16'h0001, 1'b0);
      send1(16'h8000, 16'h0001, 1'b0);
      send1(16'h7FFF, 16'hFFFF, 1'b0);
      send1(16'h1234, 16'h1233, 1'b1);
      send1(16'hBEEF, 16'hBEEF, 1'b0);
      send1(16'h0000, 16'h0000, 1'b1);
      send1(16'h0080, 16'h0081, 1'b0);

      // Backpressure: five beats, out_ready low for the first four cycles.
      for (int i = 0; i < 5; i++) begin
         bp_a[i] = 16'h1000 * 16'(i + 1) + 16'h00F0;
         bp_b[i] = 16'h0101 * 16'(i + 3);
      end
      idx = 0;
      n   = 0;
      while ((idx < 5 || q.size() > 0) && n < 40) begin
         step(idx < 5, (idx < 5) ? bp_a[idx] : 16'h0, (idx < 5) ? bp_b[idx] : 16'h0,
              1'b0, n >= 4, acc);
         if (acc) idx++;
         n++;
      end
      chk("bp_all_sent", idx, 5);
      chk("bp_all_out", q.size(), 0);

      // Reset with both stages full.
      for (int i = 0; i < 3; i++) step(1'b1, 16'h4321 + 16'(i), 16'h1111, 1'b0, 1'b0, acc);
      chk("full_before_reset", q.size(), 2);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      sif.in_valid = 1'b0;
      #1 check_reset_outputs("midreset");
      q.delete();
      @(negedge clk);
      cyc++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send1(16'hA5A5, 16'h5A5A, 1'b1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 600; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom());
         rb = ($urandom_range(0, 7) == 0) ? ra : 16'($urandom());
         step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3) != 0, acc);
      end
      drain("final_drain");

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
